// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch port, data port, RAM port and status
//               signals around mem_port_arbiter.
//               slave  : arbiter side (takes requests, drives RAM/status)
//               master : environment side (core ports plus RAM model)
// Ports       : if_*  instruction-fetch read port
//               dm_*  data load/store port
//               ram_* single-port RAM (ram_dout registered inside the RAM)
//               busy, align_err status
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              busy;
  logic              align_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_dout,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           ram_we, ram_addr, ram_din, busy, align_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_dout,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           ram_we, ram_addr, ram_din, busy, align_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester arbiter and sequencer for the shared single-port
//               RAM of the multi-cycle core. One access in flight at a time:
//               IDLE (arbitrate/latch) -> CMD (drive RAM) -> WAIT (capture
//               registered read data) -> DONE (valid pulse) -> IDLE.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-low reset
//               bus   - mem_port_arbiter_if.slave (fetch, data, RAM, status)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  wire              clk,
  input  wire              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched command
  logic              own_dm_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  // Round-robin memory: 1 = data port owned the most recent grant.
  logic              last_dm_q;

  logic              if_gnt_q, dm_gnt_q;
  logic              if_valid_q, dm_valid_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              align_err_q;

  logic              grant;
  logic              sel_dm;
  logic [31:0]       sel_addr;
  logic [1:0]        unused_addr_hi;

  // ------------------------------------------------------------------
  // Next-state / arbitration
  // ------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    // Data port wins alone, or on a tie when fetch had the last grant.
    sel_dm   = bus.dm_req & (~bus.if_req | ~last_dm_q);
    sel_addr = sel_dm ? bus.dm_addr : bus.if_addr;
    case (state_q)
      S_IDLE: begin
        if (bus.if_req | bus.dm_req) begin
          grant   = 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD:   state_d = S_WAIT;
      S_WAIT:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Upper address bits beyond the RAM are intentionally discarded (wrap).
  assign unused_addr_hi = {^sel_addr[31:ADDR_W+2], 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ------------------------------------------------------------------
  // Command latch, handshake pulses and read-data capture
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_dm_q    <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      last_dm_q   <= 1'b1;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      align_err_q <= 1'b0;
    end else begin
      if_gnt_q   <= grant & ~sel_dm;
      dm_gnt_q   <= grant & sel_dm;
      if_valid_q <= (state_q == S_WAIT) & ~own_dm_q;
      dm_valid_q <= (state_q == S_WAIT) & own_dm_q;

      if (grant) begin
        own_dm_q  <= sel_dm;
        we_q      <= sel_dm & bus.dm_we;
        waddr_q   <= sel_addr[ADDR_W+1:2];
        wdata_q   <= sel_dm ? bus.dm_wdata : '0;
        last_dm_q <= sel_dm;
        if (sel_addr[1:0] != 2'b00) align_err_q <= 1'b1;
      end

      // RAM output is valid during WAIT for the read sampled at end of CMD.
      if ((state_q == S_WAIT) && !we_q) begin
        if (own_dm_q) dm_rdata_q <= bus.ram_dout;
        else          if_rdata_q <= bus.ram_dout;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Write strobe only in CMD so a reset during CMD kills it immediately.
  assign bus.ram_we    = (state_q == S_CMD) & we_q;
  assign bus.ram_addr  = waddr_q;
  assign bus.ram_din   = wdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.align_err = align_err_q;

endmodule
`default_nettype wire
